// File: rtl/sub_serial_pkg.sv
// Shared arithmetic helpers and state encoding for the serial subtractor.
package sub_serial_pkg;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/sub_chunk.sv
// Combinational D-bit slice of the borrow chain: {cout, s} = a + ~b + cin.
module sub_chunk #(
    parameter int unsigned D = 4
) (
    input  logic [D-1:0] a,
    input  logic [D-1:0] b,
    input  logic         cin,
    output logic [D-1:0] s,
    output logic         cout
);

    logic [D:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, ~b} + {{D{1'b0}}, cin};
        s    = sum[D-1:0];
        cout = sum[D];
    end

endmodule

// File: rtl/sub_serial.sv
// Sequential signed subtractor: out = in1 - in2, D bits per cycle, valid/ready on both sides.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int unsigned L1 = 8,
    parameter int unsigned L2 = 8,
    parameter int unsigned D  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [L1-1:0]             in1,
    input  logic [L2-1:0]             in2,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [max_w(L1, L2):0]    out,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int unsigned LM = max_w(L1, L2);
    localparam int unsigned N  = LM + 1;
    localparam int unsigned K  = ceil_div(N, D);
    localparam int unsigned P  = K * D;
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

    state_e         state_q, state_d;
    logic [P-1:0]   a_q, a_d;
    logic [P-1:0]   b_q, b_d;
    logic [P-1:0]   res_q, res_d;
    logic [N-1:0]   out_q, out_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic [D-1:0]   sum;
    logic           cout;
    logic [P-1:0]   res_next;

    sub_chunk #(
        .D(D)
    ) u_chunk (
        .a    (a_q[D-1:0]),
        .b    (b_q[D-1:0]),
        .cin  (carry_q),
        .s    (sum),
        .cout (cout)
    );

    // New chunk enters at the MSB end; written as a shift of the concatenation so K=1 works too.
    assign res_next = P'({sum, res_q} >> D);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        out_d       = out_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d        = {{(P - L1){in1[L1-1]}}, in1};
                    b_d        = {{(P - L2){in2[L2-1]}}, in2};
                    carry_d    = 1'b1;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = StCalc;
                end
            end
            StCalc: begin
                a_d     = $signed(a_q) >>> D;
                b_d     = $signed(b_q) >>> D;
                carry_d = cout;
                res_d   = res_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(K - 1)) begin
                    out_d       = res_next[N-1:0];
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_sub_serial.sv
// Bench for sub_serial: four configurations checked against plain integer subtraction.
module tb_sub_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] in1_s       [4];
    logic [7:0] in2_s       [4];
    logic       in_valid_s  [4];
    logic       out_ready_s [4];
    logic [8:0] out_s       [4];
    logic       in_ready_s  [4];
    logic       out_valid_s [4];

    int vectors    = 0;
    int miscompares = 0;
    int lat_tab [4] = '{4, 4, 10, 2};

    // Unit 0: 8/8/D4, unit 1: 4/8/D4, unit 2: 8/8/D1, unit 3: 8/8/D9.
    sub_serial #(.L1(8), .L2(8), .D(4)) u_d4 (
        .clk(clk), .rst(rst), .in1(in1_s[0]), .in2(in2_s[0]), .in_valid(in_valid_s[0]),
        .in_ready(in_ready_s[0]), .out(out_s[0]), .out_valid(out_valid_s[0]),
        .out_ready(out_ready_s[0])
    );
    sub_serial #(.L1(4), .L2(8), .D(4)) u_mix (
        .clk(clk), .rst(rst), .in1(in1_s[1][3:0]), .in2(in2_s[1]), .in_valid(in_valid_s[1]),
        .in_ready(in_ready_s[1]), .out(out_s[1]), .out_valid(out_valid_s[1]),
        .out_ready(out_ready_s[1])
    );
    sub_serial #(.L1(8), .L2(8), .D(1)) u_d1 (
        .clk(clk), .rst(rst), .in1(in1_s[2]), .in2(in2_s[2]), .in_valid(in_valid_s[2]),
        .in_ready(in_ready_s[2]), .out(out_s[2]), .out_valid(out_valid_s[2]),
        .out_ready(out_ready_s[2])
    );
    sub_serial #(.L1(8), .L2(8), .D(9)) u_d9 (
        .clk(clk), .rst(rst), .in1(in1_s[3]), .in2(in2_s[3]), .in_valid(in_valid_s[3]),
        .in_ready(in_ready_s[3]), .out(out_s[3]), .out_valid(out_valid_s[3]),
        .out_ready(out_ready_s[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on unit u; hold > 0 keeps out_ready low that many cycles after out_valid.
    task automatic xact(input int u, input int x, input int y, input int hold);
        logic [8:0] exp_out;
        int         lat;
        exp_out = 9'(x - y);
        chk("in_ready_idle", 32'(in_ready_s[u]), 1);
        in1_s[u]       = 8'(x);
        in2_s[u]       = 8'(y);
        in_valid_s[u]  = 1'b1;
        out_ready_s[u] = (hold == 0);
        tick();
        in_valid_s[u] = 1'b0;
        lat = 1;
        while (out_valid_s[u] !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", lat, lat_tab[u]);
        chk("out", 32'(out_s[u]), 32'(exp_out));
        for (int i = 0; i < hold; i++) begin
            in_valid_s[u] = 1'b1;
            in1_s[u]      = 8'($urandom);
            in2_s[u]      = 8'($urandom);
            tick();
            chk("bp_valid", 32'(out_valid_s[u]), 1);
            chk("bp_out", 32'(out_s[u]), 32'(exp_out));
            chk("bp_in_ready", 32'(in_ready_s[u]), 0);
        end
        in_valid_s[u]  = 1'b0;
        out_ready_s[u] = 1'b1;
        tick();
        chk("post_in_ready", 32'(in_ready_s[u]), 1);
        chk("post_out_valid", 32'(out_valid_s[u]), 0);
        chk("post_out_hold", 32'(out_s[u]), 32'(exp_out));
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 4; u++) begin
            in1_s[u]       = '0;
            in2_s[u]       = '0;
            in_valid_s[u]  = 1'b0;
            out_ready_s[u] = 1'b1;
        end
        tick();
        tick();
        rst = 1'b0;
        for (int u = 0; u < 4; u++) begin
            chk("rst_in_ready", 32'(in_ready_s[u]), 1);
            chk("rst_out_valid", 32'(out_valid_s[u]), 0);
            chk("rst_out", 32'(out_s[u]), 0);
        end

        xact(0, 100, -28, 0);
        xact(0, -128, 127, 0);
        xact(0, 127, -128, 0);
        xact(1, -8, 127, 0);
        xact(1, 7, -128, 0);
        xact(0, 33, -77, 5);

        // Reset in the middle of CALC discards the in-flight result.
        in1_s[0]      = 8'(50);
        in2_s[0]      = 8'(9);
        in_valid_s[0] = 1'b1;
        tick();
        in_valid_s[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid_s[0]), 0);
        chk("midrst_in_ready", 32'(in_ready_s[0]), 1);
        chk("midrst_out", 32'(out_s[0]), 0);
        xact(0, 5, 3, 0);

        for (int u = 0; u < 4; u++) begin
            for (int n = 0; n < 6; n++) begin
                int x;
                int y;
                x = (u == 1) ? int'($urandom_range(0, 15)) - 8 : int'($urandom_range(0, 255)) - 128;
                y = int'($urandom_range(0, 255)) - 128;
                xact(u, x, y, ($urandom_range(0, 3) == 0) ? 2 : 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
